// File: rtl/ts_gen_mlane.sv
// Multi-lane TS1/TS2 ordered-set generator feeding the per-lane TX FIFOs.
// Define TS_GEN_EIEOS_EN to insert an EIEOS beat every EIEOS_INTERVAL TS beats.
package ts_gen_pkg;
    localparam logic [7:0] COM       = 8'hBC;
    localparam logic [7:0] PADG12    = 8'hF7;
    localparam logic [7:0] TS1_IDTFR = 8'h4A;
    localparam logic [7:0] TS2_IDTFR = 8'h45;

    localparam logic [3:0] ST_DETECT   = 4'h0;
    localparam logic [3:0] ST_POLL     = 4'h1;
    localparam logic [3:0] ST_CFG      = 4'h2;
    localparam logic [3:0] ST_L0       = 4'h3;
    localparam logic [3:0] ST_RECOVERY = 4'h4;

    localparam logic [3:0] SUB_POLL_ACTIVE     = 4'h0;
    localparam logic [3:0] SUB_POLL_CONFIG     = 4'h1;
    localparam logic [3:0] SUB_POLL_COMPLIANCE = 4'h2;

    localparam logic [3:0] SUB_CFG_LW_START  = 4'h0;
    localparam logic [3:0] SUB_CFG_LW_ACCEPT = 4'h1;
    localparam logic [3:0] SUB_CFG_LN_WAIT   = 4'h2;
    localparam logic [3:0] SUB_CFG_LN_ACCEPT = 4'h3;
    localparam logic [3:0] SUB_CFG_COMPLETE  = 4'h4;
    localparam logic [3:0] SUB_CFG_IDLE      = 4'h5;

    localparam logic MODE_DSP = 1'b0;
    localparam logic MODE_USP = 1'b1;
endpackage

module ts_gen_mlane
    import ts_gen_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned CNT_W          = 16,
    parameter logic [7:0]  N_FTS          = 8'h20,
    parameter logic [5:0]  RATE_SUPPORT   = 6'b000011,
    parameter int unsigned EIEOS_INTERVAL = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               ts_info,
    input  logic                     ts_update,
    output logic                     ts_update_ack,
    input  logic                     ts_stop,
    input  logic                     mode,
    input  logic [7:0]               link_num,
    input  logic                     lane_rev,
    input  logic [CNT_W-1:0]         target_cfg,
    input  logic                     ts_tx_fifo_full,
    output logic                     ts_valid,
    output logic [128*NUM_LANES-1:0] ts,
    output logic                     ts_is_eieos,
    output logic                     to_tsa_ts_sent_enough
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state;
    logic                     ts_update_d;
    logic                     upd_evt;
    logic                     eie_due;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         target;
    logic [128*NUM_LANES-1:0] syms;
    logic [128*NUM_LANES-1:0] next_syms;
    logic [3:0]               st;
    logic [3:0]               sub;
    logic                     pad_link;
    logic                     pad_lane;
    logic [7:0]               id_sym;

    assign st      = ts_info[7:4];
    assign sub     = ts_info[3:0];
    assign upd_evt = ts_update & ~ts_update_d;

    // Link is real only for a DSP in Configuration past LW_START; lane also for a USP.
    assign pad_link = (st != ST_CFG) || (mode == MODE_USP) || (sub == SUB_CFG_LW_START);
    assign pad_lane = (st != ST_CFG) || (sub == SUB_CFG_LW_START);
    assign id_sym   = ((st == ST_POLL && sub != SUB_POLL_ACTIVE) ||
                       (st == ST_CFG && sub == SUB_CFG_COMPLETE)) ? TS2_IDTFR : TS1_IDTFR;

    always_comb begin
        next_syms = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            next_syms[128*l +: 128] = {
                COM,
                pad_link ? PADG12 : link_num,
                pad_lane ? PADG12 : (lane_rev ? 8'(NUM_LANES - 1 - l) : 8'(l)),
                N_FTS,
                {2'b00, RATE_SUPPORT},
                8'h00,
                {10{id_sym}}
            };
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            ts_update_d           <= 1'b0;
            // NOTE: the symbol register is reset too so ts reads 0 during reset, not X.
            syms                  <= '0;
            target                <= '0;
            cnt                   <= '0;
            to_tsa_ts_sent_enough <= 1'b0;
            ts_update_ack         <= 1'b0;
            ts_valid              <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here; branches below only raise them.
            ts_update_d   <= ts_update;
            ts_update_ack <= 1'b0;
            ts_valid      <= 1'b0;
            if (state == SEND && ts_stop) begin
                state                 <= IDLE;
                cnt                   <= '0;
                to_tsa_ts_sent_enough <= 1'b0;
            end else if (upd_evt) begin
                state                 <= SEND;
                syms                  <= next_syms;
                target                <= target_cfg;
                cnt                   <= '0;
                to_tsa_ts_sent_enough <= 1'b0;
                ts_update_ack         <= 1'b1;
            end else if (state == SEND) begin
                if (cnt >= target) to_tsa_ts_sent_enough <= 1'b1;
                if (!ts_tx_fifo_full) begin
                    ts_valid <= 1'b1;
                    if (!eie_due && cnt != '1) cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef TS_GEN_EIEOS_EN
    localparam int unsigned EIE_W = $clog2(EIEOS_INTERVAL + 1);

    logic [EIE_W-1:0] eie_cnt;
    logic             accept;

    assign eie_due = (eie_cnt == EIE_W'(EIEOS_INTERVAL));
    assign accept  = (state == SEND) && !ts_stop && !upd_evt && !ts_tx_fifo_full;

    // A due EIEOS waits here until a beat is accepted, so backpressure cannot drop it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eie_cnt     <= '0;
            ts_is_eieos <= 1'b0;
        end else begin
            ts_is_eieos <= accept && eie_due;
            if (upd_evt || ts_stop) eie_cnt <= '0;
            else if (accept)        eie_cnt <= eie_due ? '0 : eie_cnt + EIE_W'(1);
        end
    end
`else
    assign eie_due     = 1'b0;
    assign ts_is_eieos = 1'b0;
`endif

    assign ts = ts_is_eieos ? {NUM_LANES{{8{16'h00FF}}}} : syms;

endmodule

// File: tb/tb_ts_gen_mlane.sv
// Randomised self-checking bench for ts_gen_mlane against a rule-level model.
// Honours TS_GEN_EIEOS_EN with EIEOS_INTERVAL = 4.
module tb_ts_gen_mlane;
    import ts_gen_pkg::*;

    localparam int NL = 4;
    localparam int EI = 4;
    localparam logic [7:0] NFTS = 8'h20;
    localparam logic [5:0] RATE = 6'b000011;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      ts_info;
    logic            ts_update;
    logic            ts_update_ack;
    logic            ts_stop;
    logic            mode;
    logic [7:0]      link_num;
    logic            lane_rev;
    logic [15:0]     target_cfg;
    logic            ts_tx_fifo_full;
    logic            ts_valid;
    logic [511:0]    ts;
    logic            ts_is_eieos;
    logic            sent_enough;

    int vectors = 0;
    int miscompares = 0;
    bit full_pat [64];

    ts_gen_mlane #(
        .NUM_LANES(NL), .CNT_W(16), .N_FTS(NFTS), .RATE_SUPPORT(RATE), .EIEOS_INTERVAL(EI)
    ) dut (
        .clk(clk), .rst(rst), .ts_info(ts_info), .ts_update(ts_update),
        .ts_update_ack(ts_update_ack), .ts_stop(ts_stop), .mode(mode),
        .link_num(link_num), .lane_rev(lane_rev), .target_cfg(target_cfg),
        .ts_tx_fifo_full(ts_tx_fifo_full), .ts_valid(ts_valid), .ts(ts),
        .ts_is_eieos(ts_is_eieos), .to_tsa_ts_sent_enough(sent_enough)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Training set built symbol by symbol from the LTSSM state rules.
    function automatic logic [511:0] exp_syms(input logic [7:0] info, input logic md,
                                              input logic [7:0] lk, input logic rv);
        logic [7:0]   sym [16];
        logic [7:0]   id;
        logic [511:0] v;
        v = '0;
        for (int l = 0; l < NL; l++) begin
            sym[0] = COM;
            sym[3] = NFTS;
            sym[4] = {2'b00, RATE};
            sym[5] = 8'h00;
            case (info[7:4])
                ST_POLL: begin
                    sym[1] = PADG12;
                    sym[2] = PADG12;
                    id = (info[3:0] == SUB_POLL_ACTIVE) ? TS1_IDTFR : TS2_IDTFR;
                end
                ST_CFG: begin
                    sym[1] = (md == MODE_USP || info[3:0] == SUB_CFG_LW_START) ? PADG12 : lk;
                    sym[2] = (info[3:0] == SUB_CFG_LW_START) ? PADG12 : (rv ? 8'(NL - 1 - l) : 8'(l));
                    id = (info[3:0] == SUB_CFG_COMPLETE) ? TS2_IDTFR : TS1_IDTFR;
                end
                default: begin
                    sym[1] = PADG12;
                    sym[2] = PADG12;
                    id = TS1_IDTFR;
                end
            endcase
            for (int i = 6; i < 16; i++) sym[i] = id;
            for (int i = 0; i < 16; i++) v[128*l + 127 - 8*i -: 8] = sym[i];
        end
        return v;
    endfunction

    function automatic logic [7:0] pick_info(input int unsigned k);
        case (k % 8)
            0: return {ST_POLL, SUB_POLL_ACTIVE};
            1: return {ST_POLL, SUB_POLL_CONFIG};
            2: return {ST_CFG, SUB_CFG_LW_START};
            3: return {ST_CFG, SUB_CFG_LW_ACCEPT};
            4: return {ST_CFG, SUB_CFG_LN_ACCEPT};
            5: return {ST_CFG, SUB_CFG_COMPLETE};
            6: return {ST_L0, 4'h1};
            default: return {ST_RECOVERY, 4'h2};
        endcase
    endfunction

    // Issues an update edge (fresh start or reload), then runs ncyc cycles with
    // the backpressure pattern in full_pat; rise is the cycle sent_enough first rose.
    task automatic run_scenario(input logic [7:0] info, input logic md, input logic [7:0] lk,
                                input logic rv, input logic [15:0] tgt, input int ncyc,
                                input bit do_stop, output int rise);
        logic [511:0] exp_ts;
        logic [511:0] eie_pat;
        int  m_cnt, m_since;
        bit  m_en, en_next, exp_v, exp_e;
        exp_ts  = exp_syms(info, md, lk, rv);
        eie_pat = {NL{{8{16'h00FF}}}};
        ts_info = info; mode = md; link_num = lk; lane_rev = rv; target_cfg = tgt;
        ts_stop = 1'b0; ts_tx_fifo_full = 1'b0; ts_update = 1'b1;
        tick();
        ts_update = 1'b0;
        vectors++;
        if (ts_update_ack !== 1'b1 || ts_valid !== 1'b0 || sent_enough !== 1'b0) begin
            miscompares++;
            $display("FAIL update_entry: ack=%b valid=%b enough=%b want 1 0 0",
                     ts_update_ack, ts_valid, sent_enough);
        end
        // Inputs captured at update; disturbing them now must not matter.
        link_num = 8'($urandom); lane_rev = 1'($urandom); target_cfg = 16'($urandom);
        m_cnt = 0; m_since = 0; m_en = 1'b0; rise = -1;
        for (int k = 1; k <= ncyc; k++) begin
            ts_tx_fifo_full = full_pat[k-1];
            tick();
            en_next = m_en || (m_cnt >= int'(tgt));
            exp_v = !full_pat[k-1];
            exp_e = 1'b0;
            if (exp_v) begin
`ifdef TS_GEN_EIEOS_EN
                if (m_since == EI) begin
                    exp_e = 1'b1;
                    m_since = 0;
                end else begin
                    m_since++;
                    if (m_cnt < 65535) m_cnt++;
                end
`else
                if (m_cnt < 65535) m_cnt++;
`endif
            end
            m_en = en_next;
            if (m_en && rise < 0) rise = k;
            vectors++;
            if (ts_valid !== exp_v || sent_enough !== m_en || ts_update_ack !== 1'b0 ||
                ts_is_eieos !== exp_e) begin
                miscompares++;
                $display("FAIL cycle %0d flags: valid=%b enough=%b ack=%b eieos=%b want %b %b 0 %b",
                         k, ts_valid, sent_enough, ts_update_ack, ts_is_eieos, exp_v, m_en, exp_e);
            end
            if (exp_v) begin
                vectors++;
                if (ts !== (exp_e ? eie_pat : exp_ts)) begin
                    miscompares++;
                    $display("FAIL cycle %0d ts: got %h want %h", k, ts, exp_e ? eie_pat : exp_ts);
                end
            end
        end
        ts_tx_fifo_full = 1'b0;
        if (do_stop) begin
            ts_stop = 1'b1;
            tick();
            ts_stop = 1'b0;
            vectors++;
            if (ts_valid !== 1'b0 || sent_enough !== 1'b0 || ts_update_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL stop: valid=%b enough=%b ack=%b want 0 0 0",
                         ts_valid, sent_enough, ts_update_ack);
            end
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (ts_valid !== 1'b0 || ts_update_ack !== 1'b0 || sent_enough !== 1'b0 ||
            ts_is_eieos !== 1'b0 || ts !== '0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b ack=%b enough=%b eieos=%b ts=%h want all 0",
                     ts_valid, ts_update_ack, sent_enough, ts_is_eieos, ts);
        end
    endtask

    task automatic test_dsp_cfg();
        int r;
        for (int i = 0; i < 8; i++) full_pat[i] = 1'b0;
        run_scenario({ST_CFG, SUB_CFG_LW_ACCEPT}, MODE_DSP, 8'h05, 1'b1, 16'd20, 2, 1'b0, r);
        vectors++;
        if (ts[111:104] !== 8'd3 || ts[495:488] !== 8'd0 || ts[119:112] !== 8'h05 ||
            ts[375:368] !== 8'h05 || ts[79:72] !== TS1_IDTFR) begin
            miscompares++;
            $display("FAIL dsp_lanes: l0s2=%h l3s2=%h l0s1=%h l2s1=%h l0s6=%h want 03 00 05 05 4a",
                     ts[111:104], ts[495:488], ts[119:112], ts[375:368], ts[79:72]);
        end
        ts_stop = 1'b1;
        tick();
        ts_stop = 1'b0;
    endtask

    task automatic test_poll_continuous();
        int r;
        int want;
        for (int i = 0; i < 16; i++) full_pat[i] = 1'b0;
        run_scenario({ST_POLL, SUB_POLL_ACTIVE}, MODE_DSP, 8'h11, 1'b0, 16'd8, 14, 1'b1, r);
`ifdef TS_GEN_EIEOS_EN
        want = 10;
`else
        want = 9;
`endif
        vectors++;
        if (r != want) begin
            miscompares++;
            $display("FAIL poll_enough_rise: got cycle %0d want %0d", r, want);
        end
    endtask

    task automatic test_backpressure();
        int r;
        int want;
        for (int i = 0; i < 24; i++) full_pat[i] = (i >= 3 && i < 8);
        run_scenario({ST_POLL, SUB_POLL_ACTIVE}, MODE_USP, 8'h22, 1'b0, 16'd8, 20, 1'b1, r);
`ifdef TS_GEN_EIEOS_EN
        want = 15;
`else
        want = 14;
`endif
        vectors++;
        if (r != want) begin
            miscompares++;
            $display("FAIL backpressure_enough_rise: got cycle %0d want %0d", r, want);
        end
    endtask

    task automatic test_target_zero();
        int r;
        for (int i = 0; i < 4; i++) full_pat[i] = 1'b1;
        run_scenario({ST_CFG, SUB_CFG_LN_WAIT}, MODE_DSP, 8'h09, 1'b0, 16'd0, 3, 1'b1, r);
        vectors++;
        if (r != 1) begin
            miscompares++;
            $display("FAIL target_zero_rise: got cycle %0d want 1", r);
        end
    endtask

    task automatic test_reload_and_stop();
        int r;
        for (int i = 0; i < 8; i++) full_pat[i] = 1'b0;
        run_scenario({ST_POLL, SUB_POLL_ACTIVE}, MODE_DSP, 8'h01, 1'b0, 16'd1, 4, 1'b0, r);
        run_scenario({ST_CFG, SUB_CFG_COMPLETE}, MODE_DSP, 8'h07, 1'b0, 16'd3, 6, 1'b0, r);
        vectors++;
        if (ts[79:72] !== TS2_IDTFR || r != 4) begin
            miscompares++;
            $display("FAIL reload_ts2: s6=%h rise=%0d want 45 4", ts[79:72], r);
        end
        ts_stop = 1'b1;
        ts_update = 1'b1;
        tick();
        ts_stop = 1'b0;
        ts_update = 1'b0;
        vectors++;
        if (ts_update_ack !== 1'b0 || ts_valid !== 1'b0 || sent_enough !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_beats_update: ack=%b valid=%b enough=%b want 0 0 0",
                     ts_update_ack, ts_valid, sent_enough);
        end
        tick();
        tick();
        vectors++;
        if (ts_valid !== 1'b0 || ts_update_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_stop: valid=%b ack=%b want 0 0", ts_valid, ts_update_ack);
        end
        // Stop while idle must not block an update.
        ts_stop = 1'b1;
        ts_update = 1'b1;
        tick();
        ts_update = 1'b0;
        ts_stop = 1'b0;
        vectors++;
        if (ts_update_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_in_idle: ack=%b want 1", ts_update_ack);
        end
        ts_stop = 1'b1;
        tick();
        ts_stop = 1'b0;
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 40; i++) full_pat[i] = ($urandom_range(0, 9) < 3);
            run_scenario(pick_info($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                         16'($urandom_range(0, 14)), 32, n[0], r);
        end
        ts_stop = 1'b1;
        tick();
        ts_stop = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        int r;
        for (int i = 0; i < 4; i++) full_pat[i] = 1'b0;
        run_scenario({ST_CFG, SUB_CFG_LW_ACCEPT}, MODE_DSP, 8'h33, 1'b0, 16'd0, 3, 1'b0, r);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (ts_valid !== 1'b0 || ts_update_ack !== 1'b0 || sent_enough !== 1'b0 ||
            ts_is_eieos !== 1'b0 || ts !== '0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b ack=%b enough=%b eieos=%b ts=%h want all 0",
                     ts_valid, ts_update_ack, sent_enough, ts_is_eieos, ts);
        end
        tick();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (ts_valid !== 1'b0 || ts_update_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: valid=%b ack=%b want 0 0", ts_valid, ts_update_ack);
        end
    endtask

    initial begin
        rst = 1'b0;
        ts_info = '0; ts_update = 1'b0; ts_stop = 1'b0; mode = 1'b0;
        link_num = '0; lane_rev = 1'b0; target_cfg = '0; ts_tx_fifo_full = 1'b0;
        #2;
        test_reset();
        tick();
        tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_dsp_cfg();
        test_poll_continuous();
        test_backpressure();
        test_target_zero();
        test_reload_and_stop();
        test_random();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
